// File: rtl/score_keeper_pkg.sv
// Shared types and helpers for the score_keeper block: FSM state encoding,
// score-width helper and the LED thermometer encoder.
package score_pkg;

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        WON  = 1'b1
    } state_t;

    // Widest LED segment the thermometer encoder can produce.
    localparam int MAX_SEG = 256;

    function automatic int score_width(input int wins);
        return (wins < 1) ? 1 : $clog2(wins + 1);
    endfunction

    function automatic logic [MAX_SEG-1:0] therm(input int count, input int width);
        logic [MAX_SEG-1:0] t;
        t = {MAX_SEG{1'b0}};
        for (int i = 0; i < MAX_SEG; i++) begin
            if ((i < count) && (i < width)) begin
                t[i] = 1'b1;
            end else begin
                t[i] = 1'b0;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/score_keeper_blink_timer.sv
// Half-period timer for the winner blink: phase toggles every BLINK_DIV cycles,
// held at count 0 / phase on while restart is asserted.
module blink_timer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] cnt_r;
    logic          phase_r;

    // Counter and phase register; restart parks the timer at the start of an on phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {BW{1'b0}};
            phase_r <= 1'b1;
        end else if (restart) begin
            cnt_r   <= {BW{1'b0}};
            phase_r <= 1'b1;
        end else if (cnt_r == LAST) begin
            cnt_r   <= {BW{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + BW'(1);
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/score_keeper.sv
// N-player score counter with match-over detection and blinking winner LEDs.
// Optional macro SCORE_KEEPER_SYNC_EN adds a two-flop synchroniser on win.
module score_keeper
    import score_pkg::*;
#(
    parameter int N_PLAYERS     = 2,
    parameter int WINS_TO_MATCH = 8,
    parameter int LED_WIDTH     = 16,
    parameter int BLINK_DIV     = 25_000_000,
    localparam int CW = score_width(WINS_TO_MATCH),
    localparam int PW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_PLAYERS-1:0]    win,
    input  logic                    clear_scores,
    output logic [LED_WIDTH-1:0]    LED,
    output logic [N_PLAYERS*CW-1:0] score,
    output logic                    match_over,
    output logic [PW-1:0]           match_winner
);

    localparam int SEG = LED_WIDTH / N_PLAYERS;
    localparam logic [CW-1:0] TARGET = CW'(WINS_TO_MATCH);
    localparam logic [CW-1:0] NEAR   = CW'(WINS_TO_MATCH - 1);

    logic [N_PLAYERS-1:0] win_s;
    logic [N_PLAYERS-1:0] win_q_r;
    logic [N_PLAYERS-1:0] rise_s;
    logic [N_PLAYERS-1:0] reached_s;

    state_t        state_r, state_s;
    logic [CW-1:0] score_r [N_PLAYERS];
    logic [CW-1:0] score_s [N_PLAYERS];
    logic          over_r, over_s;
    logic [PW-1:0] winner_r, winner_s;
    logic          blink_restart_s;
    logic          blink_phase_s;

`ifdef SCORE_KEEPER_SYNC_EN
    logic [N_PLAYERS-1:0] sync_a_r, sync_b_r;

    // Two-flop synchroniser; ones at reset so a held win is not seen as a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a_r <= {N_PLAYERS{1'b1}};
            sync_b_r <= {N_PLAYERS{1'b1}};
        end else begin
            sync_a_r <= win;
            sync_b_r <= sync_a_r;
        end
    end

    assign win_s = sync_b_r;
`else
    assign win_s = win;
`endif

    // Edge-detect history, sampled every cycle regardless of state or clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_q_r <= {N_PLAYERS{1'b1}};
        end else begin
            win_q_r <= win_s;
        end
    end

    assign rise_s = win_s & ~win_q_r;

    // Next-state, score update and winner selection; clear outranks any rise.
    always_comb begin
        state_s   = state_r;
        over_s    = over_r;
        winner_s  = winner_r;
        reached_s = {N_PLAYERS{1'b0}};
        for (int i = 0; i < N_PLAYERS; i++) begin
            score_s[i] = score_r[i];
        end
        if (clear_scores) begin
            state_s  = PLAY;
            over_s   = 1'b0;
            winner_s = {PW{1'b0}};
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_s[i] = {CW{1'b0}};
            end
        end else begin
            case (state_r)
                PLAY: begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (rise_s[i] && (score_r[i] != TARGET)) begin
                            score_s[i]   = score_r[i] + CW'(1);
                            reached_s[i] = (score_r[i] == NEAR);
                        end else begin
                            score_s[i]   = score_r[i];
                        end
                    end
                    if (|reached_s) begin
                        state_s = WON;
                        over_s  = 1'b1;
                        // Descending scan so the lowest reaching index is written last.
                        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                            winner_s = reached_s[i] ? PW'(i) : winner_s;
                        end
                    end else begin
                        state_s = PLAY;
                    end
                end
                WON: begin
                    state_s = WON;
                end
                default: begin
                    state_s = PLAY;
                end
            endcase
        end
    end

    // State, score and match result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= PLAY;
            over_r   <= 1'b0;
            winner_r <= {PW{1'b0}};
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_r[i] <= {CW{1'b0}};
            end
        end else begin
            state_r  <= state_s;
            over_r   <= over_s;
            winner_r <= winner_s;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_r[i] <= score_s[i];
            end
        end
    end

    assign blink_restart_s = (state_r != WON);

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clock   (clock),
        .reset   (reset),
        .restart (blink_restart_s),
        .phase   (blink_phase_s)
    );

    // Flatten the score registers onto the packed output bus.
    always_comb begin
        score = {(N_PLAYERS*CW){1'b0}};
        for (int i = 0; i < N_PLAYERS; i++) begin
            score[i*CW +: CW] = score_r[i];
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_seg
        logic [SEG-1:0] seg_s;

        // Winner segment blinks in WON; every other segment shows its score.
        always_comb begin
            if ((state_r == WON) && (winner_r == PW'(g))) begin
                seg_s = {SEG{blink_phase_s}};
            end else begin
                seg_s = SEG'(therm(int'(score_r[g]), SEG));
            end
        end

        assign LED[g*SEG +: SEG] = seg_s;
    end

    assign match_over   = over_r;
    assign match_winner = winner_r;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised successor of the two-player score counter that drives the board LEDs from the game's win pulses.
- Supports N players, a configurable match length and a configurable LED width.
- Adds match-over detection, a blinking winner segment and a synchronous score clear.
- Sits between the game engine (win outputs) and the LED bank in the top level.

Parameters:
- N_PLAYERS, 2: number of players; must be >= 2.
- WINS_TO_MATCH, 8: rounds needed to win the match; must be >= 1.
- LED_WIDTH, 16: LED bus width; must be divisible by N_PLAYERS.
- BLINK_DIV, 25_000_000: clock cycles per half-period of the winner blink; must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- win  in  N_PLAYERS  per-player round-win; level or pulse, counted on rising edge.
- clear_scores  in  1  synchronous, one-cycle; starts a new match.
- LED  out  LED_WIDTH  score display.
- score  out  N_PLAYERS*CW  flat packed scores; player i at [i*CW +: CW], CW = $clog2(WINS_TO_MATCH+1).
- match_over  out  1  high while the match is decided.
- match_winner  out  PW  index of the winning player; PW = max(1, $clog2(N_PLAYERS)).

Behaviour:
- Reset (reset=0, asynchronous):
  - all scores 0; match_over 0; match_winner 0; LED 0.
  - FSM in PLAY; blink counter 0; blink phase on.
  - edge-detect history win_q set to all ones, so a win held high across reset release is not counted.
- Edge detect: rise[i] = win[i] & ~win_q[i]; win_q <= win every cycle, in every state.
- Latency: rise at cycle n -> score and LED updated at n+1.
- FSM states: PLAY, WON.
- PLAY:
  - each rise[i] increments score[i]; multiple simultaneous rises all increment in the same cycle.
  - if any player's score becomes WINS_TO_MATCH, the FSM enters WON on that same update.
  - on entering WON: match_over=1; match_winner = lowest index that reached the target that cycle.
  - blink counter cleared and blink phase set to on when entering WON.
- WON:
  - all rises ignored; scores frozen.
  - blink counter counts 0..BLINK_DIV-1, toggling the blink phase on wrap.
- clear_scores (either state): scores 0, match_over 0, match_winner 0, FSM to PLAY, next cycle.
  - win_q keeps sampling, so a held win is not re-counted.
  - clear has priority over a same-cycle rise: that rise is dropped.
- Scores saturate at WINS_TO_MATCH; no wrap.
- LED mapping (combinational from registers):
  - SEG = LED_WIDTH/N_PLAYERS; player i owns LED[i*SEG +: SEG].
  - Each segment is a thermometer of min(score[i], SEG) filled from the segment LSB.
  - In WON, the winner's segment is all ones when the blink phase is on and all zeros when off; other segments show scores.
- Reset mid-match or mid-blink returns to the reset state immediately.

Optional Feature:
- Macro: SCORE_KEEPER_SYNC_EN.
- Defined: win passes through a two-flop synchroniser (reset value all ones) before edge detect; rise-to-score latency becomes 3 cycles.
- Undefined: win is used directly; latency is 1 cycle.

Decomposition:
- Package score_pkg holds:
  - state_t enum {PLAY, WON};
  - function therm(count, width) returning the thermometer code;
  - localparam helper for CW.
- One sub-module: blink_timer (BLINK_DIV parameter; inputs clock, reset, restart; output phase).
- Edge detect and the FSM stay in score_keeper.

Test Plan:
- Defaults; one-cycle pulses on win[0] x3 -> score0=3, LED=16'h0007, match_over=0; each update one cycle after its pulse.
- win[1] held high 20 cycles -> counted once: score1=1, LED[15:8]=8'h01.
- Simultaneous win=2'b11 when both scores are 7 -> both become 8, match_over=1, match_winner=0; LED[7:0] blinks (BLINK_DIV=4 in bench) with 4-cycle half-period; LED[15:8]=8'hFF steady.
- In WON, further win pulses -> scores unchanged. clear_scores plus win[0] rise in the same cycle -> next cycle scores 0, PLAY, LED=0, rise dropped.
- reset asserted mid-blink while win[0] held high; release -> all outputs 0 and no count after release until win[0] falls and rises again.
- N_PLAYERS=4, LED_WIDTH=16, WINS_TO_MATCH=6: player 3 wins six rounds -> match_winner=3, LED[15:12] blinks, score field [11:9]=6.
